vexec_unit: RTL

Lane-serial vector execute stage sitting directly downstream of the vector register file and feeding its write port. It captures two operand vectors (up to 5 x 32-bit lanes, taken from register-file read ports rd1..rd5 and rd6..rd10), computes one lane per cycle, then issues a single write-back cycle carrying wd1..wd5, we3 and wa3 back into the register file. A start/busy/done handshake lets the control unit stall while the unit works.

---
 rtl/vexec_if.sv | 38 +++
 rtl/vexec_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/vexec_if.sv
// Handshake and data bundle between the control unit / register file and
// the lane-serial vector execute stage. The sat signal exists only when
// VEXEC_SAT_EN is defined.
interface vexec_if;
  logic        start;
  logic        vector_op;
  logic [2:0]  vector_size;
  logic [2:0]  alu_ctrl;
  logic [3:0]  wa_in;
  logic [31:0] a0, a1, a2, a3, a4;
  logic [31:0] b0, b1, b2, b3, b4;
  logic        busy;
  logic        done;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd1, wd2, wd3, wd4, wd5;
`ifdef VEXEC_SAT_EN
  logic        sat;
`endif

  modport master (
    output start, vector_op, vector_size, alu_ctrl, wa_in,
           a0, a1, a2, a3, a4, b0, b1, b2, b3, b4,
    input  busy, done, we3, wa3, wd1, wd2, wd3, wd4, wd5
`ifdef VEXEC_SAT_EN
    , sat
`endif
  );

  modport slave (
    input  start, vector_op, vector_size, alu_ctrl, wa_in,
           a0, a1, a2, a3, a4, b0, b1, b2, b3, b4,
    output busy, done, we3, wa3, wd1, wd2, wd3, wd4, wd5
`ifdef VEXEC_SAT_EN
    , sat
`endif
  );
endinterface

// File: rtl/vexec_unit.sv
// Lane-serial vector execute stage. Latches two operand vectors, computes
// one lane per cycle in RUN, then issues a single write-back cycle.
// Optional feature macro: VEXEC_SAT_EN (signed-saturating ADD/SUB plus sat flag).
module vexec_unit #(
  parameter int MAX_LANES = 5,
  parameter int OPW       = 3
) (
  input  logic   clk,
  input  logic   reset,
  vexec_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [31:0]    r_a   [MAX_LANES];
  logic [31:0]    r_b   [MAX_LANES];
  logic [31:0]    r_res [MAX_LANES];
  logic [OPW-1:0] r_op;
  logic [3:0]     r_wa;
  logic [3:0]     r_wa3;
  logic [2:0]     r_n;
  logic [2:0]     r_idx;
  logic           r_satAny;

  logic           w_accept;
  logic [2:0]     w_nIn;
  logic           w_lastLane;
  logic [31:0]    w_opA;
  logic [31:0]    w_opB;
  logic [31:0]    w_sum;
  logic [31:0]    w_diff;
  logic [31:0]    w_lane;
  logic           w_laneSat;

  assign w_accept   = (r_state == IDLE) && bus.start && bus.vector_op;
  assign w_nIn      = (bus.vector_size > 3'(MAX_LANES)) ? 3'(MAX_LANES) : bus.vector_size;
  assign w_lastLane = (r_idx == (r_n - 3'd1));
  assign w_opA      = r_a[r_idx];
  assign w_opB      = r_b[r_idx];
  assign w_sum      = w_opA + w_opB;
  assign w_diff     = w_opA - w_opB;

  // Per-lane ALU: evaluates the currently indexed lane pair.
  always_comb begin
    w_lane    = '0;
    w_laneSat = 1'b0;
    case (r_op)
      3'b000: begin
        w_lane = w_sum;
`ifdef VEXEC_SAT_EN
        if ((w_opA[31] == w_opB[31]) && (w_sum[31] != w_opA[31])) begin
          w_lane    = w_opA[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          w_laneSat = 1'b1;
        end
`endif
      end
      3'b001: begin
        w_lane = w_diff;
`ifdef VEXEC_SAT_EN
        if ((w_opA[31] != w_opB[31]) && (w_diff[31] != w_opA[31])) begin
          w_lane    = w_opA[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          w_laneSat = 1'b1;
        end
`endif
      end
      3'b010:  w_lane = w_opA & w_opB;
      3'b011:  w_lane = w_opA | w_opB;
      3'b100:  w_lane = w_opA * w_opB;
      3'b101:  w_lane = w_opA ^ w_opB;
      default: w_lane = '0;
    endcase
  end

  // Next-state logic: zero-length vectors skip RUN, RUN ends on the last active lane.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_nIn == 3'd0) ? WRITE : RUN;
      RUN:     if (w_lastLane) w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Operand capture, lane-by-lane result accumulation and destination latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LANES; i++) begin
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_res[i] <= '0;
      end
      r_op     <= '0;
      r_wa     <= '0;
      r_wa3    <= '0;
      r_n      <= '0;
      r_idx    <= '0;
      r_satAny <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a[0] <= bus.a0; r_a[1] <= bus.a1; r_a[2] <= bus.a2; r_a[3] <= bus.a3; r_a[4] <= bus.a4;
            r_b[0] <= bus.b0; r_b[1] <= bus.b1; r_b[2] <= bus.b2; r_b[3] <= bus.b3; r_b[4] <= bus.b4;
            for (int i = 0; i < MAX_LANES; i++) r_res[i] <= '0;
            r_op     <= bus.alu_ctrl;
            r_wa     <= bus.wa_in;
            r_wa3    <= (w_nIn == 3'd0) ? bus.wa_in : 4'd0;
            r_n      <= w_nIn;
            r_idx    <= '0;
            r_satAny <= 1'b0;
          end
        end
        RUN: begin
          r_res[r_idx] <= w_lane;
          r_idx        <= r_idx + 3'd1;
          r_satAny     <= r_satAny | w_laneSat;
          if (w_lastLane) r_wa3 <= r_wa;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == WRITE);
  assign bus.we3  = (r_state == WRITE) && (r_n != 3'd0);
  assign bus.wa3  = r_wa3;
  assign bus.wd1  = r_res[0];
  assign bus.wd2  = r_res[1];
  assign bus.wd3  = r_res[2];
  assign bus.wd4  = r_res[3];
  assign bus.wd5  = r_res[4];
`ifdef VEXEC_SAT_EN
  assign bus.sat  = (r_state == WRITE) && r_satAny;
`endif

endmodule
